// File: rtl/conv_addr_gen_if.sv
// Address stream between the convolution address generator and the buffers it
// drives. The master presents addresses and the slave accepts each beat with ready.
interface conv_addr_gen_if #(
    parameter int ADDR_W = 8,
    parameter int FA_W   = 4
);
    logic              ready;
    logic              addr_valid;
    logic [ADDR_W-1:0] ifmap_addr;
    logic [FA_W-1:0]   filt_addr;
    logic              last_in_window;

    modport master (
        input  ready,
        output addr_valid, ifmap_addr, filt_addr, last_in_window
    );

    modport slave (
        output ready,
        input  addr_valid, ifmap_addr, filt_addr, last_in_window
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Convolution address generator: sweeps a FILT_SIZE x FILT_SIZE window across a
// square IF_SIZE feature map with step STRIDE. For every window position it emits
// one beat per filter tap: the feature-map address and the matching filter address.
module conv_addr_gen #(
    parameter int IF_SIZE   = 16,
    parameter int FILT_SIZE = 4,
    parameter int STRIDE    = 1,
    parameter int ADDR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    conv_addr_gen_if.master  bus
);
    localparam int N_OUT = (IF_SIZE - FILT_SIZE) / STRIDE + 1;
    localparam int FA_W  = $clog2(FILT_SIZE * FILT_SIZE);
    localparam int F_W   = (FILT_SIZE > 1) ? $clog2(FILT_SIZE) : 1;
    localparam int O_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [F_W-1:0] F_MAX = F_W'(FILT_SIZE - 1);
    localparam logic [O_W-1:0] O_MAX = O_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [F_W-1:0] fc;
    logic [F_W-1:0] fr;
    logic [O_W-1:0] oc;
    logic [O_W-1:0] orow;
    logic           accept;
    logic           fc_last;
    logic           fr_last;
    logic           oc_last;
    logic           orow_last;
    logic           sweep_last;

    // A beat leaves only in RUN, so acceptance is decided from the state directly.
    assign accept     = (state == RUN) && bus.ready;
    assign fc_last    = (fc == F_MAX);
    assign fr_last    = (fr == F_MAX);
    assign oc_last    = (oc == O_MAX);
    assign orow_last  = (orow == O_MAX);
    assign sweep_last = fc_last && fr_last && oc_last && orow_last;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision: start is only looked at in IDLE; FIN always lasts one cycle.
    // NOTE: the default assignment first guarantees no path leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && sweep_last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap and window counters, innermost fc; they advance only on accepted beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fc   <= '0;
            fr   <= '0;
            oc   <= '0;
            orow <= '0;
        end else if (state == IDLE && start) begin
            fc   <= '0;
            fr   <= '0;
            oc   <= '0;
            orow <= '0;
        end else if (accept) begin
            if (!fc_last) begin
                fc <= fc + 1'b1;
            end else begin
                fc <= '0;
                if (!fr_last) begin
                    fr <= fr + 1'b1;
                end else begin
                    fr <= '0;
                    if (!oc_last) begin
                        oc <= oc + 1'b1;
                    end else begin
                        oc   <= '0;
                        orow <= orow_last ? '0 : orow + 1'b1;
                    end
                end
            end
        end
    end

    // Outputs: status from the state, addresses straight from the counters.
    // Address arithmetic is done at 32 bits and then truncated to the port width.
    always_comb begin
        bus.addr_valid     = (state == RUN);
        busy               = (state == RUN) || (state == FIN);
        done               = (state == FIN);
        bus.last_in_window = (state == RUN) && fc_last && fr_last;
        bus.ifmap_addr     = ADDR_W'((32'(orow) * 32'(STRIDE) + 32'(fr)) * 32'(IF_SIZE)
                                     + 32'(oc) * 32'(STRIDE) + 32'(fc));
        bus.filt_addr      = FA_W'(32'(fr) * 32'(FILT_SIZE) + 32'(fc));
    end
endmodule

// File: tb/tb_conv_addr_gen.sv
// Directed bench for conv_addr_gen: a default-parameter instance and a STRIDE=2
// instance, driven on the falling edge and observed on the falling edge.
module tb_conv_addr_gen;
    logic clk;
    logic rst;
    logic ready;
    logic start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;

    conv_addr_gen_if #(.ADDR_W(8), .FA_W(4)) if_a ();
    conv_addr_gen_if #(.ADDR_W(8), .FA_W(4)) if_b ();

    assign if_a.ready = ready;
    assign if_b.ready = ready;

    conv_addr_gen #(.IF_SIZE(16), .FILT_SIZE(4), .STRIDE(1), .ADDR_W(8)) u_a (
        .clk   (clk),
        .rst   (rst),
        .start (start_a),
        .busy  (busy_a),
        .done  (done_a),
        .bus   (if_a.master)
    );

    conv_addr_gen #(.IF_SIZE(16), .FILT_SIZE(4), .STRIDE(2), .ADDR_W(8)) u_b (
        .clk   (clk),
        .rst   (rst),
        .start (start_b),
        .busy  (busy_b),
        .done  (done_b),
        .bus   (if_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit         sel_b = 1'b0;
    logic       cur_valid, cur_busy, cur_done, cur_lw;
    logic [7:0] cur_if;
    logic [3:0] cur_fa;

    always_comb begin
        cur_valid = sel_b ? if_b.addr_valid     : if_a.addr_valid;
        cur_busy  = sel_b ? busy_b              : busy_a;
        cur_done  = sel_b ? done_b              : done_a;
        cur_lw    = sel_b ? if_b.last_in_window : if_a.last_in_window;
        cur_if    = sel_b ? if_b.ifmap_addr     : if_a.ifmap_addr;
        cur_fa    = sel_b ? if_b.filt_addr      : if_a.filt_addr;
    end

    logic [7:0] q_if[$];
    logic [3:0] q_fa[$];
    logic       q_lw[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel_b) start_b = v;
        else       start_a = v;
    endtask

    // Independent address model: beat i decomposed into tap and window indices.
    function automatic int model_errs(input int s, input int n);
        int e;
        e = 0;
        for (int i = 0; i < q_if.size(); i++) begin
            int fc, fr, oc, orow;
            fc   = i % 4;
            fr   = (i / 4) % 4;
            oc   = (i / 16) % n;
            orow = i / (16 * n);
            if (q_if[i] !== 8'((orow * s + fr) * 16 + oc * s + fc)) e++;
            if (q_fa[i] !== 4'(fr * 4 + fc)) e++;
            if (q_lw[i] !== ((fc == 3) && (fr == 3))) e++;
        end
        return e;
    endfunction

    // One sweep: pulse start, log every accepted beat, optionally stall, re-pulse
    // start mid-sweep or in FIN, or assert reset mid-sweep.
    task automatic run_sweep(input bit use_b, input int stall_at, input int start_at,
                             input int rst_at, input bit start_in_fin, output int dones);
        int         cyc;
        bit         fin;
        logic [7:0] held_if;
        logic [3:0] held_fa;
        q_if.delete();
        q_fa.delete();
        q_lw.delete();
        dones = 0;
        fin   = 1'b0;
        sel_b = use_b;
        @(negedge clk);
        chk("idle_valid", cur_valid, 0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        chk("first_beat_valid", cur_valid, 1);
        cyc = 0;
        while (!fin && cyc < 4000) begin
            if (cur_done) dones++;
            if (cur_valid) begin
                if (q_if.size() == stall_at) begin
                    held_if = cur_if;
                    held_fa = cur_fa;
                    ready   = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        chk("stall_valid", cur_valid, 1);
                        chk("stall_ifmap", cur_if, held_if);
                        chk("stall_filt", cur_fa, held_fa);
                    end
                    ready = 1'b1;
                end
                q_if.push_back(cur_if);
                q_fa.push_back(cur_fa);
                q_lw.push_back(cur_lw);
                if (q_if.size() - 1 == start_at) set_start(1'b1);
                if (q_if.size() - 1 == rst_at) begin
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_valid", cur_valid, 0);
                    chk("rst_busy", cur_busy, 0);
                    chk("rst_done", cur_done, 0);
                    chk("rst_last", cur_lw, 0);
                    chk("rst_ifmap", cur_if, 0);
                    chk("rst_filt", cur_fa, 0);
                    repeat (2) begin
                        @(negedge clk);
                        chk("rst_hold_done", cur_done, 0);
                    end
                    rst = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        chk("post_rst_valid", cur_valid, 0);
                        chk("post_rst_busy", cur_busy, 0);
                        chk("post_rst_done", cur_done, 0);
                    end
                    fin = 1'b1;
                end
            end else begin
                chk("fin_done", cur_done, 1);
                chk("fin_busy", cur_busy, 1);
                if (start_in_fin) set_start(1'b1);
                @(negedge clk);
                set_start(1'b0);
                chk("after_fin_busy", cur_busy, 0);
                chk("after_fin_done", cur_done, 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("after_fin_idle", cur_valid, 0);
                end
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                set_start(1'b0);
                cyc++;
            end
        end
        chk("sweep_finished", fin, 1);
    endtask

    initial begin
        int dones;
        rst     = 1'b1;
        ready   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;

        // Asynchronous reset before the first clock edge.
        #3 rst = 1'b0;
        #1;
        chk("init_valid", if_a.addr_valid, 0);
        chk("init_busy", busy_a, 0);
        chk("init_done", done_a, 0);
        chk("init_ifmap", if_a.ifmap_addr, 0);
        chk("init_filt", if_a.filt_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Plain sweep, default parameters.
        run_sweep(1'b0, -1, -1, -1, 1'b0, dones);
        chk("a_beats", q_if.size(), 2704);
        chk("a_dones", dones, 1);
        chk("a_b0_ifmap", q_if[0], 0);
        chk("a_b0_filt", q_fa[0], 0);
        chk("a_b4_ifmap", q_if[4], 16);
        chk("a_b4_filt", q_fa[4], 4);
        chk("a_b14_last", q_lw[14], 0);
        chk("a_b15_ifmap", q_if[15], 51);
        chk("a_b15_filt", q_fa[15], 15);
        chk("a_b15_last", q_lw[15], 1);
        chk("a_b16_ifmap", q_if[16], 1);
        chk("a_b16_filt", q_fa[16], 0);
        chk("a_final_ifmap", q_if[2703], 255);
        chk("a_model", model_errs(1, 13), 0);

        // Backpressure at beat 7.
        run_sweep(1'b0, 7, -1, -1, 1'b0, dones);
        chk("stall_beats", q_if.size(), 2704);
        chk("stall_b7_ifmap", q_if[7], 19);
        chk("stall_b7_filt", q_fa[7], 7);
        chk("stall_b8_ifmap", q_if[8], 32);
        chk("stall_dones", dones, 1);
        chk("stall_model", model_errs(1, 13), 0);

        // start during RUN and during FIN must be ignored.
        run_sweep(1'b0, -1, 50, -1, 1'b1, dones);
        chk("restart_beats", q_if.size(), 2704);
        chk("restart_dones", dones, 1);
        chk("restart_model", model_errs(1, 13), 0);

        // Reset at beat 100 abandons the sweep; a new start begins from zero.
        run_sweep(1'b0, -1, -1, 100, 1'b0, dones);
        chk("abort_beats", q_if.size(), 101);
        chk("abort_dones", dones, 0);
        run_sweep(1'b0, -1, -1, -1, 1'b0, dones);
        chk("resweep_b0_ifmap", q_if[0], 0);
        chk("resweep_beats", q_if.size(), 2704);
        chk("resweep_dones", dones, 1);

        // STRIDE=2 instance.
        run_sweep(1'b1, -1, -1, -1, 1'b0, dones);
        chk("s2_beats", q_if.size(), 784);
        chk("s2_b16_ifmap", q_if[16], 2);
        chk("s2_b112_ifmap", q_if[112], 32);
        chk("s2_dones", dones, 1);
        chk("s2_model", model_errs(2, 7), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_addr_gen.md
CONV_ADDR_GEN -- requirements
Module: conv_addr_gen

Interface
REQ-001 Parameter IF_SIZE, default 16: side length of the square input feature map, in pixels.
REQ-002 Parameter FILT_SIZE, default 4: side length of the square filter window.
REQ-003 Parameter STRIDE, default 1: window step, in pixels, along both axes.
REQ-004 Parameter ADDR_W, default 8: ifmap_addr width; shall be >= $clog2(IF_SIZE*IF_SIZE).
REQ-005 Derived: N_OUT = (IF_SIZE-FILT_SIZE)/STRIDE+1; FA_W = $clog2(FILT_SIZE*FILT_SIZE).
REQ-006 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin one full convolution address sweep.
- ready  input  1  downstream accepts the current address beat.
- addr_valid  output  1  ifmap_addr/filt_addr hold a valid beat.
- ifmap_addr  output  ADDR_W  input feature map buffer address.
- filt_addr  output  FA_W  filter buffer address.
- last_in_window  output  1  current beat is the final tap of its window.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-007 FSM states: IDLE, RUN, FIN; encoding is free.
REQ-008 IDLE -> RUN on the clock edge where start=1.
REQ-009 start shall be ignored in RUN and FIN.
REQ-010 Four registered counters, innermost first: fc, fr (range 0..FILT_SIZE-1) and oc, orow (range 0..N_OUT-1).
REQ-011 All four counters shall be zero on entry to RUN.
REQ-012 A beat is accepted when addr_valid=1 and ready=1 in the same cycle.
REQ-013 On each accepted beat, fc increments; each counter wraps to 0 at its maximum and carries into the next outer counter.
REQ-014 With ready=0, all counters and all address outputs shall hold their values.
REQ-015 Address rules:
- ifmap_addr = (orow*STRIDE+fr)*IF_SIZE + oc*STRIDE + fc, computed without overflow and truncated to ADDR_W.
- filt_addr = fr*FILT_SIZE + fc.
- Both are combinational from the counters; no added latency.
REQ-016 addr_valid=1 exactly while in RUN.
REQ-017 busy=1 while in RUN or FIN.
REQ-018 last_in_window=1 when addr_valid=1, fc=FILT_SIZE-1 and fr=FILT_SIZE-1.
REQ-019 Final beat: the beat accepted with all four counters at their maxima moves RUN -> FIN; no further beats are issued.
REQ-020 FIN lasts exactly one cycle, with done=1 and addr_valid=0, then returns to IDLE.
REQ-021 A sweep issues exactly N_OUT*N_OUT*FILT_SIZE*FILT_SIZE beats.
REQ-022 First-beat latency: the first beat (both addresses 0) is presented in the cycle after the start edge.
REQ-023 With ready held at 1, one beat is accepted per cycle with no bubbles, including across window boundaries.
REQ-024 start=1 during FIN shall not be captured; a new sweep needs start=1 while in IDLE.

Reset
REQ-025 rst=0 shall immediately force:
- state IDLE;
- all counters 0;
- addr_valid=0, busy=0, done=0, last_in_window=0;
- ifmap_addr=0, filt_addr=0.
REQ-026 Asserting reset mid-sweep abandons the sweep; no done pulse is produced.
REQ-027 After rst returns high, the block idles until a new start.

Verification
REQ-028 Defaults, start pulse, ready=1 constant -> first beat: ifmap_addr=0, filt_addr=0; beat 4: ifmap_addr=16, filt_addr=4; beat 15: ifmap_addr=51, filt_addr=15, last_in_window=1; beat 16: ifmap_addr=1, filt_addr=0.
REQ-029 Defaults, ready=1 -> exactly 2704 accepted beats, last beat ifmap_addr=255; done=1 for one cycle on the next cycle; busy=0 the cycle after.
REQ-030 Defaults, ready=0 for 5 cycles at beat 7 -> ifmap_addr=19 and filt_addr=7 held stable with addr_valid=1; sweep continues with beat 8 (ifmap_addr=32) after ready returns to 1.
REQ-031 STRIDE=2, other parameters default -> N_OUT=7; 784 beats total; beat 16 ifmap_addr=2; beat 112 (start of orow=1) ifmap_addr=32.
REQ-032 rst=0 at beat 100 -> all outputs 0 asynchronously and no done pulse; a new start then restarts the sweep at ifmap_addr=0.
REQ-033 start pulsed at beat 50 and again during FIN -> ignored; beat count still 2704 and exactly one done pulse.
